// File: rtl/avalon_onchip_ram_pipelined_if.sv
// -----------------------------------------------------------------------------
// avalon_onchip_ram_pipelined_if
//
// Avalon-MM bus bundle between a master (processor, DMA, interconnect) and
// the pipelined on-chip RAM slave.
//
// Signals:
//   address        master -> slave  word address
//   byteenable     master -> slave  write lane enables, one bit per byte
//   chipselect     master -> slave  slave select
//   read           master -> slave  read request
//   write          master -> slave  write request
//   writedata      master -> slave  write data
//   readdata       slave -> master  read data
//   readdatavalid  slave -> master  one pulse per accepted read
//   waitrequest    slave -> master  request is not accepted this cycle
// -----------------------------------------------------------------------------
interface avalon_onchip_ram_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_onchip_ram_pipelined.sv
// -----------------------------------------------------------------------------
// avalon_onchip_ram_pipelined
//
// Single-port Avalon-MM on-chip RAM slave with configurable width and depth,
// a 1- or 2-stage pipelined read path with readdatavalid, waitrequest
// back-pressure, optional zero-clear after every reset and defined
// out-of-range behaviour (writes dropped, reads return zero).
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-high reset
//   clken      clock enable; all state advances only when clken & ~reset_req
//   reset_req  reset-pending hold request; freezes the slave like clken=0
//   init_done  high while the slave is in READY
//   bus        Avalon-MM slave modport (address, byteenable, chipselect,
//              read, write, writedata, readdata, readdatavalid, waitrequest)
// -----------------------------------------------------------------------------
module avalon_onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b0,
    parameter     INIT_FILE      = "onchip_ram.hex"
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic reset_req,
    output logic init_done,
    avalon_onchip_ram_pipelined_if.slave bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2**ADDR_WIDTH, so the range limit needs one extra bit.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic                  en;
    logic                  wait_int;
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  clear_we;

    logic [0:0]            state;
    logic [IDX_W-1:0]      clear_cnt;

    // The vendor memory flow picks up the power-up image from INIT_FILE.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  last_valid;
    logic [DATA_WIDTH-1:0] last_data;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign en        = clken & ~reset_req;
    // reset is folded in so the slave never looks ready while it is held in
    // reset, even when the reset state is READY.
    assign wait_int  = (state != ST_READY) | ~en | reset;
    assign init_done = (state == ST_READY) & ~reset;

    assign in_range  = {1'b0, bus.address} < DEPTH_LIM;
    assign word_idx  = bus.address[IDX_W-1:0];

    // wait_int already contains en, so any accept implies an enabled cycle.
    assign wr_accept = bus.chipselect & ~wait_int & bus.write;
    // Write wins when both strobes are set: the read is dropped entirely.
    assign rd_accept = bus.chipselect & ~wait_int & bus.read & ~bus.write;

    assign clear_we  = en & ~reset & (state == ST_CLEAR);

    assign bus.waitrequest = wait_int;

    // ------------------------------------------------------------------------
    // Clear sequencer: one word per enabled cycle, DEPTH cycles in total.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RESET;
            clear_cnt <= '0;
        end else if (en && state == ST_CLEAR) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            if (clear_cnt == LAST_IDX) begin
                state <= ST_READY;
            end
            clear_cnt <= clear_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // NOTE: the array has no reset branch; a reset on storage prevents RAM
    // inference and contents must survive reset when no clear is configured.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_cnt] <= '0;
        end else if (wr_accept && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline, stage 1: synchronous RAM read. The data register only
    // loads on an accepted read so readdata holds between responses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (en) begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= in_range ? mem[word_idx] : '0;
            end
        end
    end

    // Stage 2 (optional output register).
    if (READ_LATENCY == 2) begin : g_out_reg
        logic                  out_valid_q;
        logic [DATA_WIDTH-1:0] out_data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (en) begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_data_q;
                end
            end
        end

        assign last_valid = out_valid_q;
        assign last_data  = out_data_q;
    end else begin : g_no_out_reg
        assign last_valid = rd_valid_q;
        assign last_data  = rd_data_q;
    end

    // A response is only presented in an enabled cycle; while en=0 it stays
    // parked in the last stage and is delivered exactly once afterwards.
    assign bus.readdatavalid = last_valid & en;
    assign bus.readdata      = last_data;

endmodule
